eth_rx_frame_controller: RTL
============================

ETH_RX_FRAME_CONTROLLER -- requirements
Module: eth_rx_frame_controller

Interface
REQ-001 SHALL have i_clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have i_reset, input, 1, asynchronous, active-high reset; clock i_clk.
REQ-003 SHALL have i_msg_word, input, 8, received byte.
REQ-004 SHALL have i_msg_valid, input, 1, byte qualifier; a beat is any cycle with i_msg_valid=1.
REQ-005 SHALL have i_preambule_valid, input, 1, one-cycle pulse from the preamble detector on the SFD beat.
REQ-006 SHALL have o_hdr_capture, output, 1, high on every header beat; enables the header shifter.
REQ-007 SHALL have o_payload_word, output, 8, registered payload byte.
REQ-008 SHALL have o_payload_valid, output, 1, qualifies o_payload_word.
REQ-009 SHALL have o_payload_len, output, 16, payload length latched from the header.
REQ-010 SHALL have o_frame_done, output, 1, one-cycle pulse at frame end.
REQ-011 SHALL have o_frame_err, output, 1, one-cycle pulse on abort.
REQ-012 SHALL have o_state, output, 3, current FSM state encoding.

Function
REQ-013 SHALL implement states IDLE=0, HEADER=1, PAYLOAD=2, FCS=3, DONE=4.
REQ-014 SHALL move IDLE->HEADER on i_preambule_valid=1 and clear the header, payload and FCS counters to 0.
REQ-015 SHALL count 42 header beats (index 0..41) in HEADER, with o_hdr_capture combinationally equal to i_msg_valid while in HEADER.
REQ-016 SHALL latch header bytes 38 and 39 as UDP length = {byte38, byte39}.
REQ-017 SHALL, on header beat 41, compute o_payload_len = UDP length - 8 as a 16-bit value.
REQ-018 SHALL, on header beat 41, pulse o_frame_err and go to IDLE if UDP length < 8.
REQ-019 SHALL, on header beat 41, go to FCS if o_payload_len = 0, and to PAYLOAD otherwise.
REQ-020 SHALL, in PAYLOAD, register each beat to o_payload_word with o_payload_valid=1 one cycle later (latency 1).
REQ-021 SHALL leave PAYLOAD for FCS after exactly o_payload_len beats.
REQ-022 SHALL, in FCS, consume 4 beats without forwarding them, then enter DONE.
REQ-023 SHALL stay in DONE for one cycle with o_frame_done=1, then return to IDLE; DONE ignores the beat in that cycle.
REQ-024 SHALL treat i_preambule_valid=1 in HEADER, PAYLOAD or FCS as an abort-and-restart: pulse o_frame_err, enter HEADER, clear all counters.
REQ-025 SHALL let a preamble pulse in DONE start HEADER without an error pulse, and that cycle SHALL still assert o_frame_done.
REQ-026 SHALL hold all counters and state on cycles with i_msg_valid=0; non-beat cycles never advance the FSM.

Reset
REQ-027 SHALL, on i_reset=1, force state IDLE, all counters 0, and o_payload_word=0, o_payload_valid=0, o_payload_len=0, o_frame_done=0, o_frame_err=0.
REQ-028 SHALL drop o_hdr_capture to 0 immediately on reset.
REQ-029 SHALL discard an in-flight frame on reset mid-operation, with no done or error pulse.

Configuration
REQ-030 SHALL compile in a gap watchdog when ETH_RX_CTRL_WDOG_EN is defined.
REQ-031 SHALL make the watchdog count consecutive i_msg_valid=0 cycles in HEADER, PAYLOAD or FCS; on reaching 16 it SHALL pulse o_frame_err and go to IDLE.
REQ-032 SHALL, without ETH_RX_CTRL_WDOG_EN, omit the watchdog logic entirely, so gaps stall the FSM indefinitely.

Structure
REQ-033 SHALL take the state encoding, HDR_LEN=42, UDP_LEN_HI_IDX=38, UDP_HDR_LEN=8, FCS_LEN=4 and WDOG_LIMIT=16 from shared package eth_rx_pkg.
REQ-034 SHALL implement the watchdog as sub-module eth_rx_gap_watchdog (inputs: clear and tick; output: expire).

Verification
REQ-035 SHALL test the nominal frame: preamble pulse, 42 header beats with bytes 38/39 = 0x00/0x0C, 4 payload beats 0xA1..0xA4, 4 FCS beats -> o_payload_len=4, o_payload_word A1..A4 each 1 cycle after its input beat, o_frame_done pulse one cycle after the last FCS beat.
REQ-036 SHALL test a zero payload: UDP length 0x0008 -> PAYLOAD skipped, o_payload_valid never 1, o_frame_done after 4 FCS beats.
REQ-037 SHALL test a short length: UDP length 0x0005 -> o_frame_err pulse on beat 41, FSM back to IDLE, no o_frame_done.
REQ-038 SHALL test abort-and-restart: preamble pulse at payload beat 2 -> o_frame_err pulse, o_state=HEADER, the next frame completes normally.
REQ-039 SHALL test gaps: i_msg_valid low for 10 cycles mid-header -> counters held, frame completes; with ETH_RX_CTRL_WDOG_EN and a 16-cycle gap -> o_frame_err pulse and IDLE.
REQ-040 SHALL test reset mid-payload: i_reset asserted -> all outputs 0 immediately, o_state=IDLE, no pulses.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared constants for the Ethernet/UDP receive frame controller:
// FSM state encoding, header/trailer lengths and gap watchdog limit.
package eth_rx_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_HEADER  = 3'd1;
  localparam logic [STATE_W-1:0] ST_PAYLOAD = 3'd2;
  localparam logic [STATE_W-1:0] ST_FCS     = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  // Ethernet(14) + IPv4(20) + UDP(8) header bytes; UDP length sits at 38/39
  localparam logic [5:0]  HDR_LEN        = 6'd42;
  localparam logic [5:0]  HDR_LAST_IDX   = HDR_LEN - 6'd1;
  localparam logic [5:0]  UDP_LEN_HI_IDX = 6'd38;
  localparam logic [5:0]  UDP_LEN_LO_IDX = UDP_LEN_HI_IDX + 6'd1;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
  localparam logic [2:0]  FCS_LEN        = 3'd4;
  localparam logic [2:0]  FCS_LAST_IDX   = FCS_LEN - 3'd1;

  localparam int unsigned WDOG_CNT_W = 5;
  localparam logic [WDOG_CNT_W-1:0] WDOG_LIMIT = 5'd16;

endpackage

// File: rtl/eth_rx_frame_controller_if.sv
// Byte-stream input and frame-status output bundle of the receive frame
// controller. master = stream source / consumer, slave = controller.
interface eth_rx_frame_controller_if;

  logic [7:0]  i_msg_word;
  logic        i_msg_valid;
  logic        i_preambule_valid;

  logic        o_hdr_capture;
  logic [7:0]  o_payload_word;
  logic        o_payload_valid;
  logic [15:0] o_payload_len;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [2:0]  o_state;

  modport master (
    output i_msg_word, i_msg_valid, i_preambule_valid,
    input  o_hdr_capture, o_payload_word, o_payload_valid, o_payload_len,
           o_frame_done, o_frame_err, o_state
  );

  modport slave (
    input  i_msg_word, i_msg_valid, i_preambule_valid,
    output o_hdr_capture, o_payload_word, o_payload_valid, o_payload_len,
           o_frame_done, o_frame_err, o_state
  );

endinterface

// File: rtl/eth_rx_gap_watchdog.sv
// Counts consecutive idle (tick) cycles; expire fires combinationally on the
// WDOG_LIMIT-th consecutive tick. clear restarts the count.
module eth_rx_gap_watchdog
  import eth_rx_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  logic [WDOG_CNT_W-1:0] gap_cnt;

  assign expire = tick && (gap_cnt == (WDOG_LIMIT - 5'd1));

  // Gap counter: restarts on clear or expiry, otherwise advances per tick
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gap_cnt <= '0;
    end else if (clear || expire) begin
      gap_cnt <= '0;
    end else if (tick) begin
      gap_cnt <= gap_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/eth_rx_frame_controller.sv
// Receive frame controller: parses a 42-byte Ethernet/IPv4/UDP header,
// extracts the UDP length, forwards the payload with one cycle of latency,
// skips the 4-byte FCS and signals frame completion or abort.
// Optional gap watchdog compiled in with ETH_RX_CTRL_WDOG_EN.
module eth_rx_frame_controller
  import eth_rx_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  eth_rx_frame_controller_if.slave   bus
);

  logic [STATE_W-1:0] state;
  logic [5:0]         hdr_cnt;
  logic [15:0]        pay_cnt;
  logic [2:0]         fcs_cnt;
  logic [7:0]         udp_hi;
  logic [7:0]         udp_lo;
  logic [15:0]        udp_len;
  logic [15:0]        payload_len;
  logic [7:0]         payload_word;
  logic               payload_valid;
  logic               frame_done;
  logic               frame_err;
  logic               wdog_expire;

  assign udp_len = {udp_hi, udp_lo};

`ifdef ETH_RX_CTRL_WDOG_EN
  logic in_frame;
  logic wdog_clear;
  logic wdog_tick;

  // A preamble restarts the frame, so it also restarts the gap count
  assign in_frame   = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_FCS);
  assign wdog_tick  = in_frame && !bus.i_msg_valid && !bus.i_preambule_valid;
  assign wdog_clear = !wdog_tick;

  eth_rx_gap_watchdog u_gap_watchdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (wdog_clear),
    .tick    (wdog_tick),
    .expire  (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  assign bus.o_hdr_capture   = (state == ST_HEADER) && bus.i_msg_valid;
  assign bus.o_payload_word  = payload_word;
  assign bus.o_payload_valid = payload_valid;
  assign bus.o_payload_len   = payload_len;
  assign bus.o_frame_done    = frame_done;
  assign bus.o_frame_err     = frame_err;
  assign bus.o_state         = state;

  // Frame FSM, beat counters and registered payload/status outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
      fcs_cnt       <= '0;
      udp_hi        <= '0;
      udp_lo        <= '0;
      payload_len   <= '0;
      payload_word  <= '0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;

      // A preamble pre-empts any beat processing; it is an abort only when
      // a frame is still in progress (DONE has already completed its frame).
      if (bus.i_preambule_valid) begin
        state   <= ST_HEADER;
        hdr_cnt <= '0;
        pay_cnt <= '0;
        fcs_cnt <= '0;
        if ((state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_FCS)) begin
          frame_err <= 1'b1;
        end
      end else if (wdog_expire) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end

          ST_HEADER: begin
            if (bus.i_msg_valid) begin
              hdr_cnt <= hdr_cnt + 6'd1;
              if (hdr_cnt == UDP_LEN_HI_IDX) udp_hi <= bus.i_msg_word;
              if (hdr_cnt == UDP_LEN_LO_IDX) udp_lo <= bus.i_msg_word;
              if (hdr_cnt == HDR_LAST_IDX) begin
                payload_len <= udp_len - UDP_HDR_LEN;
                if (udp_len < UDP_HDR_LEN) begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
                end else if (udp_len == UDP_HDR_LEN) begin
                  state <= ST_FCS;
                end else begin
                  state <= ST_PAYLOAD;
                end
              end
            end
          end

          ST_PAYLOAD: begin
            if (bus.i_msg_valid) begin
              payload_word  <= bus.i_msg_word;
              payload_valid <= 1'b1;
              pay_cnt       <= pay_cnt + 16'd1;
              if (pay_cnt == (payload_len - 16'd1)) state <= ST_FCS;
            end
          end

          ST_FCS: begin
            if (bus.i_msg_valid) begin
              fcs_cnt <= fcs_cnt + 3'd1;
              if (fcs_cnt == FCS_LAST_IDX) begin
                state      <= ST_DONE;
                frame_done <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
